// File: rtl/time_counter.sv
// time_counter: mm:ss run-control counter advancing on a 1 Hz tick, up or down,
// with start/pause toggle, clear and clamped load.
module time_counter #(
   parameter int MAX_MINS = 59
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       tick,
   input  logic       start,
   input  logic       clear,
   input  logic       load,
   input  logic       dir,
   input  logic [5:0] load_mins,
   input  logic [5:0] load_secs,
   output logic [5:0] mins,
   output logic [5:0] secs,
   output logic       running,
   output logic       done,
   output logic       expired
);
   typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;
   state_t state, state_nx;
   logic [5:0] mins_nx, secs_nx, max_m;
   logic at_term, expire_nx, run_nx, done_nx;
   assign max_m = 6'(MAX_MINS);
   // terminal value for the direction currently selected
   assign at_term = dir ? (mins == '0 && secs == '0) : (mins == max_m && secs == 6'd59);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= IDLE;
         mins    <= '0;
         secs    <= '0;
         running <= 1'b0;
         done    <= 1'b0;
         expired <= 1'b0;
      end else begin
         state   <= state_nx;
         mins    <= mins_nx;
         secs    <= secs_nx;
         running <= run_nx;
         done    <= done_nx;
         expired <= expire_nx;
      end
   end
   always_comb begin
      state_nx  = state;
      mins_nx   = mins;
      secs_nx   = secs;
      expire_nx = 1'b0;
      if (clear) begin
         state_nx = IDLE;
         mins_nx  = '0;
         secs_nx  = '0;
      end else if (load) begin
         state_nx = IDLE;
         mins_nx  = load_mins > max_m ? max_m : load_mins;
         secs_nx  = load_secs > 6'd59 ? 6'd59 : load_secs;
      end else if (start) begin
         case (state)
            IDLE:    state_nx = (dir && at_term) ? IDLE : RUN;
            RUN:     state_nx = PAUSE;
            PAUSE:   state_nx = RUN;
            default: state_nx = state;
         endcase
      end else if (tick && state == RUN) begin
         if (at_term) begin
            state_nx  = DONE;
            expire_nx = 1'b1;
         end else begin
            if (dir) begin
               secs_nx = secs == '0 ? 6'd59 : secs - 6'd1;
               mins_nx = secs == '0 ? mins - 6'd1 : mins;
            end else begin
               secs_nx = secs == 6'd59 ? '0 : secs + 6'd1;
               mins_nx = secs == 6'd59 ? mins + 6'd1 : mins;
            end
            if (dir ? (mins_nx == '0 && secs_nx == '0) : (mins_nx == max_m && secs_nx == 6'd59)) begin
               state_nx  = DONE;
               expire_nx = 1'b1;
            end
         end
      end
   end
   always_comb begin
      run_nx  = state_nx == RUN;
      done_nx = state_nx == DONE;
   end
endmodule

// File: tb/tb_time_counter.sv
// tb_time_counter: directed vector table plus randomized run checked against a
// total-seconds reference model.
module tb_time_counter;
   localparam int MAX_MINS = 59;
   localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;
   logic clk = 1'b0, rst_n = 1'b0;
   logic tick = 1'b0, start = 1'b0, clear = 1'b0, load = 1'b0, dir = 1'b0;
   logic [5:0] load_mins = '0, load_secs = '0;
   logic [5:0] mins, secs;
   logic running, done, expired;
   int vectors = 0, miscompares = 0;
   int m_t = 0, m_st = M_IDLE, m_exp = 0;
   always #5 clk = ~clk;
   time_counter #(.MAX_MINS(MAX_MINS)) dut (
      .clk(clk), .rst_n(rst_n), .tick(tick), .start(start), .clear(clear), .load(load),
      .dir(dir), .load_mins(load_mins), .load_secs(load_secs), .mins(mins), .secs(secs),
      .running(running), .done(done), .expired(expired)
   );
   typedef struct {
      logic tk, st, cl, ld, dr;
      logic [5:0] lm, ls, em, es;
      logic er, ed, ee;
   } vec_t;
   vec_t tbl[$];
   task automatic check(input string name, input int em, input int es, input logic er, input logic ed, input logic ee);
      vectors++;
      if (mins !== 6'(em) || secs !== 6'(es) || running !== er || done !== ed || expired !== ee) begin
         miscompares++;
         $display("FAIL %s: got %0d:%0d run=%b done=%b exp=%b, want %0d:%0d run=%b done=%b exp=%b",
                  name, mins, secs, running, done, expired, em, es, er, ed, ee);
      end
   endtask
   // time kept as total seconds; the limits come straight from the rules
   task automatic model_step(input logic tk, st, cl, ld, dr, input int lm, ls);
      int term;
      m_exp = 0;
      term = dr ? 0 : MAX_MINS * 60 + 59;
      if (cl) begin
         m_t = 0; m_st = M_IDLE;
      end else if (ld) begin
         m_t = (lm > MAX_MINS ? MAX_MINS : lm) * 60 + (ls > 59 ? 59 : ls);
         m_st = M_IDLE;
      end else if (st) begin
         if (m_st == M_IDLE && !(dr && m_t == 0)) m_st = M_RUN;
         else if (m_st == M_RUN) m_st = M_PAUSE;
         else if (m_st == M_PAUSE) m_st = M_RUN;
      end else if (tk && m_st == M_RUN) begin
         if (m_t != term) m_t += dr ? -1 : 1;
         if (m_t == term) begin
            m_st = M_DONE; m_exp = 1;
         end
      end
   endtask
   task automatic step(input logic tk, st, cl, ld, dr, input logic [5:0] lm, ls);
      @(negedge clk);
      tick = tk; start = st; clear = cl; load = ld; dir = dr; load_mins = lm; load_secs = ls;
      model_step(tk, st, cl, ld, dr, int'(lm), int'(ls));
      @(posedge clk);
      #1;
   endtask
   task automatic add(input logic tk, st, cl, ld, dr, input int lm, ls, em, es, input logic er, ed, ee);
      tbl.push_back(vec_t'{tk, st, cl, ld, dr, 6'(lm), 6'(ls), 6'(em), 6'(es), er, ed, ee});
   endtask
   initial begin
      //   tk st cl ld dr lm  ls  em  es run done exp
      add(1, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  0,  0, 0, 0, 0);
      add(0, 0, 0, 1, 0,  0, 58,  0, 58, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0,  0, 58, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  0, 59, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  1,  0, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  1,  1, 1, 0, 0);
      add(0, 0, 0, 1, 0,  0,  2,  0,  2, 0, 0, 0);
      add(0, 1, 0, 0, 1,  0,  0,  0,  2, 1, 0, 0);
      add(1, 0, 0, 0, 1,  0,  0,  0,  1, 1, 0, 0);
      add(1, 0, 0, 0, 1,  0,  0,  0,  0, 0, 1, 1);
      add(1, 0, 0, 0, 1,  0,  0,  0,  0, 0, 1, 0);
      add(0, 1, 0, 0, 1,  0,  0,  0,  0, 0, 1, 0);
      add(1, 1, 0, 0, 0,  0,  0,  0,  0, 0, 1, 0);
      add(0, 0, 0, 1, 0, 63, 63, 59, 59, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0, 59, 59, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0, 59, 59, 0, 1, 1);
      add(0, 0, 0, 1, 0,  5,  0,  5,  0, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0,  5,  0, 1, 0, 0);
      add(1, 1, 0, 0, 0,  0,  0,  5,  0, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0,  5,  0, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0,  5,  1, 1, 0, 0);
      add(0, 0, 1, 1, 0, 10, 10,  0,  0, 0, 0, 0);
      add(0, 1, 0, 0, 1,  0,  0,  0,  0, 0, 0, 0);
      add(1, 0, 0, 0, 1,  0,  0,  0,  0, 0, 0, 0);
      add(0, 0, 0, 1, 0,  0,  1,  0,  1, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0,  0,  1, 1, 0, 0);
      add(1, 0, 0, 0, 1,  0,  0,  0,  0, 0, 1, 1);
      add(0, 0, 0, 1, 0, 59, 59, 59, 59, 0, 0, 0);
      add(0, 1, 0, 0, 0,  0,  0, 59, 59, 1, 0, 0);
      add(1, 0, 0, 0, 1,  0,  0, 59, 58, 1, 0, 0);
      add(1, 0, 0, 0, 0,  0,  0, 59, 59, 0, 1, 1);
      repeat (2) @(posedge clk);
      #1 check("reset", 0, 0, 0, 0, 0);
      @(negedge clk) rst_n = 1'b1;
      foreach (tbl[i]) begin
         step(tbl[i].tk, tbl[i].st, tbl[i].cl, tbl[i].ld, tbl[i].dr, tbl[i].lm, tbl[i].ls);
         check($sformatf("vec%0d", i), int'(tbl[i].em), int'(tbl[i].es), tbl[i].er, tbl[i].ed, tbl[i].ee);
      end
      step(0, 0, 0, 1, 0, 6'd0, 6'd30);
      check("pre_rst_load", m_t / 60, m_t % 60, m_st == M_RUN, m_st == M_DONE, m_exp != 0);
      step(0, 1, 0, 0, 0, 6'd0, 6'd0);
      check("pre_rst_start", m_t / 60, m_t % 60, m_st == M_RUN, m_st == M_DONE, m_exp != 0);
      @(negedge clk);
      tick = 1'b0; start = 1'b0; load = 1'b0; clear = 1'b0;
      #2 rst_n = 1'b0;
      #1 check("async_reset", 0, 0, 0, 0, 0);
      m_t = 0; m_st = M_IDLE; m_exp = 0;
      @(negedge clk) rst_n = 1'b1;
      for (int i = 0; i < 4000; i++) begin
         logic tk, st, cl, ld;
         logic [5:0] lm, ls;
         tk = $urandom_range(0, 1) == 0;
         st = $urandom_range(0, 19) == 0;
         cl = $urandom_range(0, 99) == 0;
         ld = $urandom_range(0, 39) == 0;
         lm = 6'($urandom_range(0, 3) == 0 ? $urandom_range(56, 63) : $urandom_range(0, 2));
         ls = 6'($urandom_range(0, 63));
         step(tk, st, cl, ld, $urandom_range(0, 15) == 0 ? ~dir : dir, lm, ls);
         check("rand", m_t / 60, m_t % 60, m_st == M_RUN, m_st == M_DONE, m_exp != 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
